piso_serializer: RTL
====================

Name:
piso_serializer

Overview:
- Parallel-in, serial-out serializer; transmit-side counterpart of the team's serial-in shift register chain.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clk on ser_out.
- ser_valid and ser_last frame the stream so the downstream deserializer knows which bits are live and where each word ends.
- Sits between a parallel producer (register file or FSM) and a 1-bit serial link.

Parameters:
- WIDTH, 4, data word width in bits; legal range is 2 or more.
- MSB_FIRST, 0, 0 = in_data[0] is sent first; 1 = in_data[WIDTH-1] is sent first.

Ports:
- clk  input  1  clock, rising edge.
- n_rst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  serializer can accept a word this cycle.
- in_data  input  WIDTH  parallel word; sampled only on accept (in_valid && in_ready).
- ser_out  output  1  serial data bit, registered.
- ser_valid  output  1  ser_out carries a live frame bit, registered.
- ser_last  output  1  ser_out is the final bit of the frame, registered.

Behaviour:
- Reset (n_rst low) is asynchronous.
  - Clears ser_out, ser_valid and ser_last to 0.
  - Clears the shift register and bit counter to 0; state goes to IDLE.
  - in_ready = 1 while in reset and after reset.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - in_ready = 1; ser_valid = 0.
  - On accept: load the shift register, set the counter to 0, go to SHIFT.
- SHIFT:
  - Each cycle, drive the next bit: ser_valid = 1, counter += 1.
  - ser_last = 1 when the counter equals FRAME_LEN-1.
- Latency: the first bit appears on ser_out one cycle after the accept edge.
- Frame length: FRAME_LEN = WIDTH (WIDTH+1 with the optional feature).
- in_ready timing:
  - in_ready = (state==IDLE) || (state==SHIFT && bit being presented is the last).
  - in_ready is a function of state and counter only. It never depends on in_valid.
- Back-to-back words: an accept during the last-bit cycle loads the next word. Its first bit follows with no gap, and ser_valid stays high.
- Last bit with no accept: the FSM returns to IDLE, and ser_valid and ser_last drop on the next cycle.
- Mid-frame, in_valid is ignored (in_ready = 0). The producer must hold in_valid and in_data until accept.
- Counter:
  - Width is max(1, $clog2(FRAME_LEN)).
  - It saturates at no value; it reloads to 0 on every accept and never wraps past FRAME_LEN-1.
- Reset mid-frame aborts the word. No residual bits are emitted after n_rst deasserts.
- ser_out = 0 whenever ser_valid = 0.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of all WIDTH data bits) is appended after the data bits.
  - FRAME_LEN = WIDTH+1; ser_last marks the parity bit.
  - in_ready's last-bit term refers to the parity cycle.
- Undefined:
  - No parity logic or parity state exists.
  - FRAME_LEN = WIDTH; ser_last marks the final data bit.

Decomposition:
- Shared package piso_pkg:
  - State enum typedef (IDLE, SHIFT).
  - Localparam helper for FRAME_LEN and counter width, under PISO_PARITY_EN.
- Natural sub-module piso_bit_cnt:
  - Load-to-zero modulo counter with a terminal flag (cnt == FRAME_LEN-1).
  - Reused by the matching deserializer.

Test Plan:
- Reset: hold n_rst low for 3 cycles, then release. Expect ser_out, ser_valid and ser_last = 0 and in_ready = 1 throughout; no bits emitted.
- Single word, WIDTH=4, MSB_FIRST=0: in_data = 4'b1011 accepted at cycle 0.
  - ser_out = 1,1,0,1 on cycles 1-4; ser_valid = 1 on cycles 1-4.
  - ser_last = 1 on cycle 4 only; ser_valid = 0 on cycle 5.
- Back-to-back: 4'hA then 4'h5, with in_valid held high.
  - 8 contiguous valid bits: 0,1,0,1,1,0,1,0.
  - in_ready high at cycles 0 and 4 only; ser_last pulses at cycles 4 and 8.
- Stall: in_valid raised at cycle 2 of a frame with 4'h3.
  - Not accepted until the last-bit cycle.
  - The next frame starts immediately after; in_data is held stable by the bench.
- MSB_FIRST=1, in_data = 4'b1000: ser_out = 1,0,0,0.
- Reset mid-frame: pulse n_rst low after bit 2 of 4'hF.
  - ser_valid drops asynchronously; in_ready = 1.
  - A new word 4'h1 then serializes cleanly as 1,0,0,0.
- Parity, with PISO_PARITY_EN defined: in_data = 4'b0111.
  - ser_out = 1,1,1,0 then parity bit 1.
  - ser_last on the 5th bit; in_ready high on the 5th bit cycle.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and frame-geometry helpers for the PISO serializer and its matching deserializer.
// Defining PISO_PARITY_EN appends one even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef PISO_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  function automatic int unsigned frame_len(input int unsigned width);
    return width + PARITY_BITS;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned flen);
    return (flen <= 2) ? 1 : $clog2(flen);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Load-to-zero modulo-FRAME_LEN bit counter with a terminal flag (cnt == FRAME_LEN-1).
module piso_bit_cnt #(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: the default assignment first means every path drives cnt_d, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready input and framed (valid/last) serial output.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int unsigned      FRAME_LEN = frame_len(WIDTH);
  localparam int unsigned      CNT_W     = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] PENULT    = CNT_W'(FRAME_LEN - 2);

  state_e               state_q, state_d;
  logic [FRAME_LEN-1:0] frame;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic                 ser_out_q, ser_out_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 ser_last_q, ser_last_d;
  logic                 accept;
  logic                 cnt_inc;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_term;

  // The counter indexes the bit currently on ser_out, so ready opens during the last bit.
  assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_term);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (state_q == SHIFT);

  piso_bit_cnt #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .load_i(accept),
    .inc_i (cnt_inc),
    .cnt_o (cnt),
    .term_o(cnt_term)
  );

  // Frame in transmission order: bit 0 goes out first.
  always_comb begin
    frame = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      frame[i] = MSB_FIRST ? in_data[int'(WIDTH) - 1 - i] : in_data[i];
    end
`ifdef PISO_PARITY_EN
    frame[FRAME_LEN-1] = ^in_data;
`endif
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;

    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_term && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      ser_out_d   = frame[0];
      ser_valid_d = 1'b1;
      shreg_d     = {1'b0, frame[FRAME_LEN-1:1]};
    end else if ((state_q == SHIFT) && !cnt_term) begin
      ser_out_d   = shreg_q[0];
      ser_valid_d = 1'b1;
      ser_last_d  = (cnt == PENULT);
      shreg_d     = {1'b0, shreg_q[FRAME_LEN-1:1]};
    end
  end

  // NOTE: the shift register is reset along with the control state so an aborted word leaves nothing behind.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;

endmodule
